// File: rtl/fxp_muldiv_arbiter.sv
// fxp_muldiv_arbiter: round-robin front end that shares one fixed-latency
// fixed-point mul/div unit between two requesters and routes each result
// back to the requester that issued it, in issue order.
// Optional feature macro: FXP_ARB_OVF_STICKY_EN adds per-requester sticky
// overflow flags on ovf_sticky; without it ovf_sticky is tied to zero.
module fxp_muldiv_arbiter #(
  parameter int unsigned WII = 12,
  parameter int unsigned WIF = 20,
  parameter int unsigned WO  = 41,
  parameter int unsigned LAT = 43
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_op,
  input  logic [WII+WIF-1:0]   req0_a,
  input  logic [WII+WIF-1:0]   req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_op,
  input  logic [WII+WIF-1:0]   req1_a,
  input  logic [WII+WIF-1:0]   req1_b,
  output logic                 u_valid,
  output logic                 u_op,
  output logic [WII+WIF-1:0]   u_ina,
  output logic [WII+WIF-1:0]   u_inb,
  input  logic [WO-1:0]        u_out,
  input  logic                 u_ovf,
  output logic                 res_valid,
  output logic                 res_id,
  output logic [WO-1:0]        res_data,
  output logic                 res_ovf,
  output logic [1:0]           ovf_sticky
);

  logic           ptr;
  logic           u_id;
  logic           grant0_c;
  logic           grant1_c;
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_id;

  // Round-robin grant: a lone requester always wins, ties go to the pointer.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || !ptr)) begin
        grant0_c = 1'b1;
      end else if (req1_valid) begin
        grant1_c = 1'b1;
      end
    end
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;

  // Issue register towards the shared unit plus priority pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_valid <= 1'b0;
      u_op    <= 1'b0;
      u_ina   <= '0;
      u_inb   <= '0;
      u_id    <= 1'b0;
      ptr     <= 1'b0;
    end else begin
      u_valid <= grant0_c | grant1_c;
      if (grant0_c) begin
        u_op  <= req0_op;
        u_ina <= req0_a;
        u_inb <= req0_b;
        u_id  <= 1'b0;
        ptr   <= 1'b1;
      end else if (grant1_c) begin
        u_op  <= req1_op;
        u_ina <= req1_a;
        u_inb <= req1_b;
        u_id  <= 1'b1;
        ptr   <= 1'b0;
      end
    end
  end

  // Tag pipeline mirrors the unit latency so the id meets its own result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= u_valid;
      tag_id[0]  <= u_id;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Result capture; data and id hold between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
    end else begin
      res_valid <= tag_vld[LAT-1];
      if (tag_vld[LAT-1]) begin
        res_id   <= tag_id[LAT-1];
        res_data <= u_out;
        res_ovf  <= u_ovf;
      end
    end
  end

`ifdef FXP_ARB_OVF_STICKY_EN
  // Sticky overflow per requester, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 2'b00;
    end else if (res_valid && res_ovf) begin
      ovf_sticky[res_id] <= 1'b1;
    end
  end
`else
  assign ovf_sticky = 2'b00;
`endif

endmodule

// File: tb/tb_fxp_muldiv_arbiter.sv
// Directed bench for fxp_muldiv_arbiter with a behavioural shared mul/div unit.
module tb_fxp_muldiv_arbiter;

  localparam int unsigned WII = 12;
  localparam int unsigned WIF = 20;
  localparam int unsigned WO  = 41;
  localparam int unsigned LAT = 43;
  localparam int unsigned W   = WII + WIF;
  localparam int unsigned WOF = 17;
  localparam int unsigned MSH = 2 * WIF - WOF;

`ifdef FXP_ARB_OVF_STICKY_EN
  localparam logic [1:0] STICKY_DZ = 2'b10;
`else
  localparam logic [1:0] STICKY_DZ = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid, req0_ready, req0_op;
  logic [W-1:0]  req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_op;
  logic [W-1:0]  req1_a, req1_b;
  logic          u_valid, u_op;
  logic [W-1:0]  u_ina, u_inb;
  logic [WO-1:0] u_out;
  logic          u_ovf;
  logic          res_valid, res_id, res_ovf;
  logic [WO-1:0] res_data;
  logic [1:0]    ovf_sticky;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int h, at;
  logic          exp_id   [6];
  logic [WO-1:0] exp_data [6];

  fxp_muldiv_arbiter #(.WII(WII), .WIF(WIF), .WO(WO), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .u_valid(u_valid), .u_op(u_op), .u_ina(u_ina), .u_inb(u_inb),
    .u_out(u_out), .u_ovf(u_ovf),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ovf(res_ovf),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shared unit: fixed LAT-cycle pipeline of {ovf, out}.
  logic [WO:0] upipe [LAT];

  function automatic logic [WO:0] unit_calc(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 1'b0) begin
      r = (sa * sb) >>> MSH;
      return {1'b0, WO'(r)};
    end else if (sb == 0) begin
      return {1'b1, {WO{1'b0}}};
    end else begin
      r = (sa <<< WOF) / sb;
      return {1'b0, WO'(r)};
    end
  endfunction

  always @(posedge clk) begin
    upipe[0] <= unit_calc(u_op, u_ina, u_inb);
    for (int i = 1; i < int'(LAT); i++) upipe[i] <= upipe[i-1];
  end

  assign u_out = upipe[LAT-1][WO-1:0];
  assign u_ovf = upipe[LAT-1][WO];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_res(input string tag, input int budget, output int when);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (res_valid === 1'b1) else begin
      errors++;
      $error("FAIL %s: res_valid observed %b expected 1 within %0d cycles", tag, res_valid, budget);
    end
    when = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_valid = 1'b1; req0_op = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = '0; req1_b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state, both valids high
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_u_valid",    64'(u_valid),    64'd0);
    chk("rst_u_ina",      64'(u_ina),      64'd0);
    chk("rst_res_valid",  64'(res_valid),  64'd0);
    chk("rst_res_id",     64'(res_id),     64'd0);
    chk("rst_res_data",   64'(res_data),   64'd0);
    chk("rst_res_ovf",    64'(res_ovf),    64'd0);
    chk("rst_sticky",     64'(ovf_sticky), 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Single multiply 3.0 * 2.0
    req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h0030_0000; req0_b = 32'h0020_0000;
    #1;
    chk("mul_req0_ready", 64'(req0_ready), 64'd1);
    chk("mul_req1_ready", 64'(req1_ready), 64'd0);
    h = cyc;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("mul_u_valid", 64'(u_valid), 64'd1);
    chk("mul_u_op",    64'(u_op),    64'd0);
    chk("mul_u_ina",   64'(u_ina),   64'h0030_0000);
    chk("mul_u_inb",   64'(u_inb),   64'h0020_0000);
    @(negedge clk);
    chk("idle_u_valid", 64'(u_valid), 64'd0);
    chk("idle_u_ina",   64'(u_ina),   64'h0030_0000);
    wait_res("mul_wait", LAT + 4, at);
    chk("mul_latency",  64'(at - h),   64'(LAT + 2));
    chk("mul_res_id",   64'(res_id),   64'd0);
    chk("mul_res_data", 64'(res_data), 64'h000c_0000);
    chk("mul_res_ovf",  64'(res_ovf),  64'd0);
    @(negedge clk);
    chk("mul_res_drop", 64'(res_valid), 64'd0);
    chk("mul_res_hold", 64'(res_data),  64'h000c_0000);

    // Contention: pointer back to 0, both valid for 6 cycles
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req0_op = 1'b0; req0_a = W'((i + 1) << WIF);  req0_b = W'(1 << WIF);
      req1_valid = 1'b1; req1_op = 1'b0; req1_a = W'((i + 17) << WIF); req1_b = W'(1 << WIF);
      #1;
      chk($sformatf("cont_ready0_%0d", i), 64'(req0_ready), 64'(i % 2 == 0));
      chk($sformatf("cont_ready1_%0d", i), 64'(req1_ready), 64'(i % 2 == 1));
      if (i == 0) h = cyc;
      exp_id[i]   = 1'(i % 2);
      exp_data[i] = (i % 2 == 0) ? WO'((i + 1) << WOF) : WO'((i + 17) << WOF);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_res("cont_wait", LAT + 4, at);
    chk("cont_latency", 64'(at - h), 64'(LAT + 2));
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("cont_valid_%0d", k), 64'(res_valid), 64'd1);
      chk($sformatf("cont_id_%0d", k),    64'(res_id),    64'(exp_id[k]));
      chk($sformatf("cont_data_%0d", k),  64'(res_data),  64'(exp_data[k]));
      @(negedge clk);
    end
    chk("cont_end", 64'(res_valid), 64'd0);

    // Divide 6.0/2.0 on req0, then divide by zero on req1
    req0_valid = 1'b1; req0_op = 1'b1; req0_a = 32'h0060_0000; req0_b = 32'h0020_0000;
    #1;
    chk("div_req0_ready", 64'(req0_ready), 64'd1);
    h = cyc;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'h0010_0000; req1_b = 32'h0000_0000;
    #1;
    chk("dz_req1_ready", 64'(req1_ready), 64'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_res("div_wait", LAT + 4, at);
    chk("div_latency",  64'(at - h),     64'(LAT + 2));
    chk("div_res_id",   64'(res_id),     64'd0);
    chk("div_res_data", 64'(res_data),   64'h0006_0000);
    chk("div_res_ovf",  64'(res_ovf),    64'd0);
    chk("div_sticky",   64'(ovf_sticky), 64'd0);
    @(negedge clk);
    chk("dz_res_valid", 64'(res_valid), 64'd1);
    chk("dz_res_id",    64'(res_id),    64'd1);
    chk("dz_res_ovf",   64'(res_ovf),   64'd1);
    @(negedge clk);
    chk("dz_sticky",    64'(ovf_sticky), 64'(STICKY_DZ));
    chk("dz_res_drop",  64'(res_valid),  64'd0);
    repeat (3) @(negedge clk);
    chk("dz_sticky_hold", 64'(ovf_sticky), 64'(STICKY_DZ));

    // Reset mid-flight: three issues (0,1,0), reset at handshake+5
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h0010_0000; req0_b = 32'h0010_0000;
      req1_valid = 1'b1; req1_op = 1'b0; req1_a = 32'h0020_0000; req1_b = 32'h0010_0000;
      #1;
      chk($sformatf("mid_ready0_%0d", i), 64'(req0_ready), 64'(i % 2 == 0));
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_rst_ready0", 64'(req0_ready), 64'd0);
    chk("mid_rst_ready1", 64'(req1_ready), 64'd0);
    @(negedge clk);
    chk("mid_rst_u_valid", 64'(u_valid),    64'd0);
    chk("mid_rst_sticky",  64'(ovf_sticky), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < int'(LAT) + 4; k++) begin
      chk($sformatf("mid_no_res_%0d", k), 64'(res_valid), 64'd0);
      @(negedge clk);
    end

    // Pointer is back at requester 0
    req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h0050_0000; req0_b = 32'h0010_0000;
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = 32'h0070_0000; req1_b = 32'h0010_0000;
    #1;
    chk("ptr_ready0", 64'(req0_ready), 64'd1);
    chk("ptr_ready1", 64'(req1_ready), 64'd0);
    h = cyc;
    @(negedge clk);

    // Only req1 valid for 4 cycles
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req1_valid = 1'b1; req1_op = 1'b0; req1_a = W'((k + 1) << WIF); req1_b = W'(1 << WIF);
      #1;
      chk($sformatf("solo_ready1_%0d", k), 64'(req1_ready), 64'd1);
      chk($sformatf("solo_ready0_%0d", k), 64'(req0_ready), 64'd0);
      @(negedge clk);
    end
    req1_valid = 1'b0;
    wait_res("solo_wait", LAT + 4, at);
    chk("ptr_latency",  64'(at - h),   64'(LAT + 2));
    chk("ptr_res_id",   64'(res_id),   64'd0);
    chk("ptr_res_data", 64'(res_data), 64'h000a_0000);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("solo_valid_%0d", k), 64'(res_valid), 64'd1);
      chk($sformatf("solo_id_%0d", k),    64'(res_id),    64'd1);
      chk($sformatf("solo_data_%0d", k),  64'(res_data),  64'((k + 1) << WOF));
      @(negedge clk);
    end
    chk("solo_end", 64'(res_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxp_muldiv_arbiter.md
FXP_MULDIV_ARBITER -- requirements
Module: fxp_muldiv_arbiter

Interface
REQ-001 SHALL have parameter WII, default 12: integer bits of both operands.
REQ-002 SHALL have parameter WIF, default 20: fractional bits of both operands.
REQ-003 SHALL have parameter WO, default 41: result width, i.e. WOI+WOF of the shared unit.
REQ-004 SHALL have parameter LAT, default 43, range 1..64: fixed latency in clocks of the shared mul/div unit.
REQ-005 SHALL have port clk  in  1: the single clock.
REQ-006 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-007 SHALL have ports req0_valid, req1_valid  in  1: the requester has an operation pending.
REQ-008 SHALL have ports req0_ready, req1_ready  out  1: the operation is accepted this cycle.
REQ-009 SHALL have ports req0_op, req1_op  in  1: operation select, 0=multiply, 1=divide.
REQ-010 SHALL have ports req0_a, req0_b, req1_a, req1_b  in  WII+WIF: signed fixed-point operands (a = dividend).
REQ-011 SHALL have ports u_valid  out  1, u_op  out  1, u_ina  out  WII+WIF, u_inb  out  WII+WIF: issue to the shared unit.
REQ-012 SHALL have ports u_out  in  WO, u_ovf  in  1: shared unit result and overflow, LAT clocks after issue.
REQ-013 SHALL have ports res_valid  out  1, res_id  out  1, res_data  out  WO, res_ovf  out  1: routed result.
REQ-014 SHALL have port ovf_sticky  out  2: per-requester sticky overflow flags, present only as defined in Configuration.

Function
REQ-015 SHALL issue at most one operation per cycle; u_valid, u_op, u_ina and u_inb are registered; the issue appears at the unit one clock after the ready handshake.
REQ-016 SHALL grant a requester when its valid is high and it wins arbitration; its ready is high only in that cycle (ready is a combinational function of both valids and the priority pointer).
REQ-017 SHALL arbitrate round-robin: a 1-bit pointer names the preferred requester; after a grant the pointer moves to the other requester; with no grant it holds.
REQ-018 SHALL grant the single valid requester regardless of the pointer when only one valid is high.
REQ-019 SHALL hold u_ina, u_inb and u_op at their last values and drive u_valid=0 in cycles without an issue.
REQ-020 SHALL track each issue in a LAT-deep tag shift register {valid, id}, shifted every cycle, with its input aligned to u_valid.
REQ-021 SHALL assert res_valid in the cycle the tag leaves the shift register, with res_id = tag id and res_data/res_ovf registered from u_out/u_ovf. Total latency is LAT+2 clocks from handshake to res_valid.
REQ-022 SHALL NOT accept back-pressure on results; one result per issue, in issue order, no loss, no duplication.
REQ-023 SHALL sustain full throughput: with both valids held high, grants alternate 0,1,0,1 every cycle.
REQ-024 SHALL hold res_data and res_ovf when res_valid=0.

Reset
REQ-025 SHALL, while rst=1, clear u_valid, res_valid, every tag valid bit and ovf_sticky, set res_id=0 and the pointer to requester 0, and zero u_ina, u_inb, u_op, res_data and res_ovf.
REQ-026 SHALL discard all in-flight operations when rst is asserted mid-operation; no res_valid for those operations after release.
REQ-027 SHALL force req0_ready=req1_ready=0 while rst=1.

Configuration
REQ-028 SHALL, with macro FXP_ARB_OVF_STICKY_EN defined, set ovf_sticky[res_id] when res_valid and res_ovf are both 1; the flag clears only on reset.
REQ-029 SHALL, without FXP_ARB_OVF_STICKY_EN, drive ovf_sticky constantly to 0 and contain no sticky registers.

Verification
REQ-030 Single mul: req0 op=0, a=0x00300000 (3.0), b=0x00200000 (2.0) -> res_valid at handshake+LAT+2, res_id=0, res_data=6.0 (0x000c0000 for WOF=17), res_ovf=0.
REQ-031 Contention: both valid held 6 cycles, pointer=0 after reset -> grants 0,1,0,1,0,1; results return in the same id order, one per cycle.
REQ-032 Divide by zero: req1 op=1, b=0 -> res_id=1, res_ovf=1; with FXP_ARB_OVF_STICKY_EN ovf_sticky=2'b10, without it 2'b00.
REQ-033 Reset mid-flight: issue 3 operations, assert rst for 2 cycles at handshake+5 -> no res_valid for the next LAT+4 cycles, and the pointer is 0.
REQ-034 Idle/single requester: only req1 valid for 4 cycles -> req1_ready is high every cycle and req0_ready stays 0.
